// File: rtl/multicycle_control_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute FSM that drives the datapath selects and
// strobes, with memory wait states, bus timeout, illegal-instruction trap and a retired-instruction counter.
//
// state  | meaning
// IDLE   | post-reset bubble, always moves to FETCH
// FETCH  | instruction read, PC drives the address, IR loads on mem_ready
// DECODE | legality check of IR
// EXEC   | ALU op selected; branches resolve and retire here
// MEM    | data read/write at the ALU address until mem_ready
// WB     | register write-back and PC update, retires
// TRAP   | illegal instruction or bus timeout
module multicycle_control_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_HALT   = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [31:0]      INSN,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic [31:0]      ir,
  output logic             ir_load,
  output logic             sub_sra,
  output logic             addr_sel,
  output logic             pc_next_sel,
  output logic             pc_alu_sel,
  output logic             rd_en,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             pc_en,
  output logic [2:0]       state,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Counter only needs to reach MEM_TIMEOUT-1; the trap fires on the wait cycle that would reach the limit.
  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state_q;
  logic [TO_W-1:0] tmo_cnt;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_branch, is_load, is_store, is_jal, is_jalr, is_auipc;
  logic       alt_alu, legal, tmo_hit, retire;

  assign state     = state_q;
  assign opc       = ir[6:0];
  assign f3        = ir[14:12];
  assign f7        = ir[31:25];
  assign is_branch = (opc == OPC_BRANCH);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_auipc  = (opc == OPC_AUIPC);
  // SUB, SRA and SRAI: legal encodings with f7 bit 5 set
  assign alt_alu   = ir[30] && (((opc == OPC_OP) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                                ((opc == OPC_OPIMM) && (f3 == 3'b101)));
  assign tmo_hit   = (MEM_TIMEOUT != 0) && !mem_ready && (tmo_cnt == TO_LAST);
  assign retire    = ((state_q == S_EXEC) && is_branch) ||
                     ((state_q == S_MEM) && is_store && mem_ready) ||
                     (state_q == S_WB);

  always_comb begin
    legal = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
      OPC_JALR:   legal = (f3 == 3'b000);
      OPC_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:   legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                          (f3 == 3'b100) || (f3 == 3'b101);
      OPC_STORE:  legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OPC_OPIMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0);
        else if (f3 == 3'b101) legal = (f7 == 7'b0) || (f7 == F7_ALT);
        else                   legal = 1'b1;
      end
      OPC_OP:     legal = (f7 == 7'b0) ||
                          ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      ir         <= '0;
      trap_cause <= 2'b00;
      instret    <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          tmo_cnt <= '0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir      <= INSN;
            state_q <= S_DECODE;
          end else if (tmo_hit) begin
            state_q    <= S_TRAP;
            trap_cause <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + TO_W'(1);
          end
        end
        S_DECODE: begin
          if (legal) begin
            state_q <= S_EXEC;
          end else begin
            state_q    <= S_TRAP;
            trap_cause <= 2'b01;
          end
        end
        S_EXEC: begin
          tmo_cnt <= '0;
          if (is_load || is_store) state_q <= S_MEM;
          else if (is_branch)      state_q <= S_FETCH;
          else                     state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            state_q <= is_load ? S_WB : S_FETCH;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            state_q    <= S_TRAP;
            trap_cause <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + TO_W'(1);
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          tmo_cnt <= '0;
        end
        S_TRAP: begin
          if (!TRAP_HALT) begin
            state_q    <= S_FETCH;
            trap_cause <= 2'b00;
            tmo_cnt    <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // Outputs decode from the registered state and IR; only the mem_ready/branch_taken handshakes pass through.
  always_comb begin
    ir_load     = 1'b0;
    sub_sra     = 1'b0;
    addr_sel    = 1'b0;
    pc_next_sel = 1'b0;
    pc_alu_sel  = 1'b0;
    rd_en       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    pc_en       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        ir_load  = mem_ready;
      end
      S_EXEC: begin
        sub_sra = is_branch || alt_alu;
        if (is_branch) begin
          pc_en       = 1'b1;
          pc_alu_sel  = 1'b1;
          pc_next_sel = branch_taken;
        end
      end
      S_MEM: begin
        mem_rd = is_load;
        mem_wr = is_store;
        pc_en  = is_store && mem_ready;
      end
      S_WB: begin
        rd_en       = (ir[11:7] != 5'd0);
        pc_en       = 1'b1;
        pc_next_sel = is_jal || is_jalr;
        pc_alu_sel  = is_jal || is_auipc;
      end
      S_TRAP: pc_en = !TRAP_HALT;
      default: ;
    endcase
  end

endmodule
